dvs_ravens_mc_transmitter: RTL and testbench

- Multi-channel, backpressure-aware successor to the single-stream DVS→RAVENS transmitter.
- Merges NUM_CH timestamped spike streams and issues spike packets oldest-timestamp-first.
- Bins timestamps into SEGMENT_LENGTH_US RAVENS timesteps and emits RUN(n) and START (new sim time) packets.
- Uses a valid/ready output handshake, wrap-safe timestamp arithmetic and a stale-spike drop counter.

---
 rtl/dvs_ravens_mc_transmitter.sv | 243 ++++++++++++++++++++++++
 tb/tb_dvs_ravens_mc_transmitter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dvs_ravens_mc_transmitter.sv
// Multi-channel DVS -> RAVENS packet transmitter.
// Merges NUM_CH timestamped spike streams oldest-first, bins timestamps into
// SEGMENT_LENGTH_US timesteps, and emits START / RUN(n) / spike packets over a
// valid/ready output. Spikes that are already too old are dropped and counted.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/ready   per-channel spike handshake (one pop per cycle at most)
//   in_ts, in_pkt    per-channel timestamp / spike packet, channel i at [i*W +: W]
//   time_us          free-running microsecond time
//   out_valid/ready  output packet handshake, out_pkt held stable until accepted
//   out_pkt          spike packet, {001,count} RUN or {010,0} START
//   sim_time_start   high in the cycle the START packet is accepted
//   drop_cnt         saturating count of stale spikes dropped
module dvs_ravens_mc_transmitter #(
    parameter int NUM_CH                    = 2,
    parameter int TS_BITS                   = 32,
    parameter int PKT_BITS                  = 24,
    parameter int SEGMENT_LENGTH_US         = 25,
    parameter int NUM_SEGMENTS_PER_SIM_TIME = 10,
    parameter int SIM_TIME                  = 15,
    parameter int DROP_CNT_BITS             = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          in_valid,
    output logic [NUM_CH-1:0]          in_ready,
    input  logic [NUM_CH*TS_BITS-1:0]  in_ts,
    input  logic [NUM_CH*PKT_BITS-1:0] in_pkt,
    input  logic [TS_BITS-1:0]         time_us,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PKT_BITS-1:0]        out_pkt,
    output logic                       sim_time_start,
    output logic [DROP_CNT_BITS-1:0]   drop_cnt
);

    localparam int NW    = $clog2(SIM_TIME + 1);
    localparam int RUN_W = PKT_BITS - 3;
    localparam logic [TS_BITS-1:0] SEG_LEN   = TS_BITS'(SEGMENT_LENGTH_US);
    localparam logic [TS_BITS-1:0] STALE_LIM = TS_BITS'(SEGMENT_LENGTH_US * NUM_SEGMENTS_PER_SIM_TIME);

    if (SIM_TIME >= (1 << RUN_W) || SIM_TIME < NUM_SEGMENTS_PER_SIM_TIME) begin : g_bad_params
        $error("SIM_TIME must fit the run count field and be >= NUM_SEGMENTS_PER_SIM_TIME");
    end

    typedef enum logic [2:0] {
        S_IDLE_NEW = 3'd0,
        S_START    = 3'd1,
        S_WAIT     = 3'd2,
        S_RUN      = 3'd3,
        S_XMIT     = 3'd4
    } state_t;

    // Wrap-safe "a is after b": modular difference nonzero and in the lower half.
    function automatic logic ts_after(input logic [TS_BITS-1:0] a, input logic [TS_BITS-1:0] b);
        logic [TS_BITS-1:0] d;
        d = a - b;
        return (d != '0) && !d[TS_BITS-1];
    endfunction

    // Number of timesteps covering a positive gap, rounded up. The gap is
    // below 2^(TS_BITS-1) so the rounding add cannot overflow.
    function automatic logic [TS_BITS-1:0] ceil_segs(input logic [TS_BITS-1:0] d);
        return (d + SEG_LEN - 1'b1) / SEG_LEN;
    endfunction

    state_t                     state_q, state_d;
    logic                       out_valid_q, out_valid_d;
    logic [PKT_BITS-1:0]        out_pkt_q, out_pkt_d;
    logic [DROP_CNT_BITS-1:0]   drop_cnt_q, drop_cnt_d;
    logic [TS_BITS-1:0]         held_ts_q, held_ts_d;
    logic [PKT_BITS-1:0]        held_pkt_q, held_pkt_d;
    logic                       held_pending_q, held_pending_d;
    logic [TS_BITS-1:0]         ref_time_q, ref_time_d;
    logic [TS_BITS-1:0]         seg_last_q, seg_last_d;
    logic [NW-1:0]              step_q, step_d;
    logic [NW-1:0]              n_q, n_d;
    logic                       end_flag_q, end_flag_d;

    logic                       arb_en, win_found, pop, hs, stale;
    logic [NUM_CH-1:0]          win_oh;
    logic [TS_BITS-1:0]         win_ts, cand_ts, gap_segs;
    logic [PKT_BITS-1:0]        win_pkt;
    logic [TS_BITS:0]           step_sum;
    logic [NW-1:0]              n_new;
    logic                       end_new;

    // Oldest-first arbiter: a later channel only wins if strictly older, so
    // ties stay with the lowest index.
    always_comb begin
        arb_en    = (state_q == S_WAIT) || (state_q == S_IDLE_NEW && !held_pending_q);
        win_found = 1'b0;
        win_oh    = '0;
        win_ts    = '0;
        win_pkt   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_valid[i] && (!win_found || ts_after(win_ts, in_ts[i*TS_BITS +: TS_BITS]))) begin
                win_found = 1'b1;
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_ts    = in_ts[i*TS_BITS +: TS_BITS];
                win_pkt   = in_pkt[i*PKT_BITS +: PKT_BITS];
            end
        end
        pop      = arb_en && win_found;
        in_ready = pop ? win_oh : '0;
    end

    always_comb begin
        state_d        = state_q;
        out_valid_d    = out_valid_q;
        out_pkt_d      = out_pkt_q;
        drop_cnt_d     = drop_cnt_q;
        held_ts_d      = held_ts_q;
        held_pkt_d     = held_pkt_q;
        held_pending_d = held_pending_q;
        seg_last_d     = seg_last_q;
        step_d         = step_q;
        n_d            = n_q;
        end_flag_d     = end_flag_q;

        hs      = out_valid_q && out_ready;
        cand_ts = held_pending_q ? held_ts_q : win_ts;
        stale   = !ts_after(cand_ts, ref_time_q) && ((ref_time_q - cand_ts) >= STALE_LIM);

        gap_segs = ts_after(win_ts, seg_last_q) ? ceil_segs(win_ts - seg_last_q) : '0;
        step_sum = {1'b0, gap_segs} + (TS_BITS+1)'(step_q);
        if (step_sum >= (TS_BITS+1)'(NUM_SEGMENTS_PER_SIM_TIME)) begin
            n_new   = NW'(SIM_TIME) - step_q;
            end_new = 1'b1;
        end else begin
            n_new   = NW'(gap_segs);
            end_new = 1'b0;
        end

        if (pop) begin
            held_ts_d  = win_ts;
            held_pkt_d = win_pkt;
        end

        case (state_q)
            S_IDLE_NEW: begin
                if (held_pending_q || pop) begin
                    held_pending_d = 1'b0;
                    if (stale) begin
                        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
                    end else begin
                        state_d     = S_START;
                        out_valid_d = 1'b1;
                        out_pkt_d   = {3'b010, {RUN_W{1'b0}}};
                    end
                end
            end
            S_START: begin
                if (hs) begin
                    seg_last_d = held_ts_q;
                    step_d     = '0;
                    state_d    = S_XMIT;
                    out_pkt_d  = held_pkt_q;
                end
            end
            S_WAIT: begin
                if (pop) begin
                    n_d         = n_new;
                    end_flag_d  = end_new;
                    out_valid_d = 1'b1;
                    if (n_new != '0) begin
                        state_d   = S_RUN;
                        out_pkt_d = {3'b001, RUN_W'(n_new)};
                    end else begin
                        state_d   = S_XMIT;
                        out_pkt_d = win_pkt;
                    end
                end
            end
            S_RUN: begin
                if (hs) begin
                    seg_last_d = seg_last_q + TS_BITS'(n_q) * SEG_LEN;
                    step_d     = step_q + n_q;
                    if (end_flag_q) begin
                        // Spike that overflowed the sim time is replayed from IDLE_NEW.
                        held_pending_d = 1'b1;
                        state_d        = S_IDLE_NEW;
                        out_valid_d    = 1'b0;
                        out_pkt_d      = '0;
                    end else begin
                        state_d   = S_XMIT;
                        out_pkt_d = held_pkt_q;
                    end
                end
            end
            S_XMIT: begin
                if (hs) begin
                    state_d     = S_WAIT;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE_NEW;
                out_valid_d = 1'b0;
            end
        endcase

        ref_time_d = (state_d == S_IDLE_NEW) ? time_us : ref_time_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE_NEW;
            out_valid_q    <= 1'b0;
            out_pkt_q      <= '0;
            drop_cnt_q     <= '0;
            held_ts_q      <= '0;
            held_pkt_q     <= '0;
            held_pending_q <= 1'b0;
            ref_time_q     <= '0;
            seg_last_q     <= '0;
            step_q         <= '0;
            n_q            <= '0;
            end_flag_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            out_valid_q    <= out_valid_d;
            out_pkt_q      <= out_pkt_d;
            drop_cnt_q     <= drop_cnt_d;
            held_ts_q      <= held_ts_d;
            held_pkt_q     <= held_pkt_d;
            held_pending_q <= held_pending_d;
            ref_time_q     <= ref_time_d;
            seg_last_q     <= seg_last_d;
            step_q         <= step_d;
            n_q            <= n_d;
            end_flag_q     <= end_flag_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_pkt        = out_pkt_q;
    assign drop_cnt       = drop_cnt_q;
    assign sim_time_start = (state_q == S_START) && hs;

endmodule

// File: tb/tb_dvs_ravens_mc_transmitter.sv
// Directed bench for dvs_ravens_mc_transmitter: START/XMIT/RUN sequencing,
// oldest-first arbitration, stale drops with saturation, backpressure,
// timestamp wrap and asynchronous reset.
module tb_dvs_ravens_mc_transmitter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [63:0] in_ts;
    logic [47:0] in_pkt;
    logic [31:0] time_us;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_pkt;
    logic        sim_time_start;
    logic [15:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    dvs_ravens_mc_transmitter dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_ts(in_ts),
        .in_pkt(in_pkt),
        .time_us(time_us),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pkt(out_pkt),
        .sim_time_start(sim_time_start),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_ch(input int ch, input logic v, input logic [31:0] ts, input logic [23:0] pkt);
        in_valid[ch]         = v;
        in_ts[ch*32 +: 32]   = ts;
        in_pkt[ch*24 +: 24]  = pkt;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = '0; in_ts = '0; in_pkt = '0;
        time_us = 32'd1010; out_ready = 1'b0;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pkt", 32'(out_pkt), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_sim_start", 32'(sim_time_start), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: first spike -> START, then spike (seg_last=1000, step=0)
        set_ch(0, 1'b1, 32'd1000, 24'h000AAA); settle();
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        tick(); in_valid = '0; settle();
        chk("t1_start_valid", 32'(out_valid), 32'd1);
        chk("t1_start_pkt", 32'(out_pkt), 32'h400000);
        chk("t1_start_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1; settle();
        chk("t1_sim_start", 32'(sim_time_start), 32'd1);
        tick();
        chk("t1_xmit_pkt", 32'(out_pkt), 32'h000AAA);
        chk("t1_xmit_no_start", 32'(sim_time_start), 32'd0);
        tick();
        chk("t1_wait_valid", 32'(out_valid), 32'd0);

        // 2: ts=1000 -> spike only; ts=1051 -> RUN 3 with 5 cycles of backpressure
        set_ch(0, 1'b1, 32'd1000, 24'h000BBB); settle();
        chk("t2_in_ready", 32'(in_ready), 32'd1);
        tick(); in_valid = '0;
        chk("t2_xmit_pkt", 32'(out_pkt), 32'h000BBB);
        tick();
        out_ready = 1'b0;
        set_ch(0, 1'b1, 32'd1051, 24'h000CCC);
        tick();
        set_ch(0, 1'b1, 32'd1060, 24'h000CCD); settle();
        chk("t2_run_pkt", 32'(out_pkt), 32'h200003);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_bp_valid", 32'(out_valid), 32'd1);
            chk("t6_bp_pkt", 32'(out_pkt), 32'h200003);
            chk("t6_bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = '0; out_ready = 1'b1;
        tick();
        chk("t2_spike_pkt", 32'(out_pkt), 32'h000CCC);
        tick();

        // 3: step=3, seg_last=1075, ts=1300 -> RUN 12, replay held spike
        out_ready = 1'b0;
        set_ch(0, 1'b1, 32'd1300, 24'h000DDD);
        tick(); in_valid = '0;
        chk("t3_run_pkt", 32'(out_pkt), 32'h20000C);
        time_us = 32'd1310; out_ready = 1'b1;
        tick();
        chk("t3_idle_valid", 32'(out_valid), 32'd0);
        set_ch(1, 1'b1, 32'd1305, 24'h000999); settle();
        chk("t3_held_no_pop", 32'(in_ready), 32'd0);
        tick(); in_valid = '0;
        chk("t3_start_pkt", 32'(out_pkt), 32'h400000);
        chk("t3_sim_start", 32'(sim_time_start), 32'd1);
        tick();
        chk("t3_held_spike", 32'(out_pkt), 32'h000DDD);
        tick();

        // 5: oldest first (ch1 1305 before ch0 1310), seg_last=1300 step=0
        set_ch(0, 1'b1, 32'd1310, 24'h000E10);
        set_ch(1, 1'b1, 32'd1305, 24'h000E05); settle();
        chk("t5_oldest_ch1", 32'(in_ready), 32'd2);
        tick(); in_valid[1] = 1'b0; settle();
        chk("t5_run1_pkt", 32'(out_pkt), 32'h200001);
        chk("t5_run_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("t5_ch1_spike", 32'(out_pkt), 32'h000E05);
        tick();
        chk("t5_then_ch0", 32'(in_ready), 32'd1);
        tick(); in_valid = '0;
        chk("t5_ch0_spike", 32'(out_pkt), 32'h000E10);
        tick();
        set_ch(0, 1'b1, 32'd1325, 24'h000F00);
        set_ch(1, 1'b1, 32'd1325, 24'h000F01); settle();
        chk("t5_tie_ch0", 32'(in_ready), 32'd1);
        tick(); in_valid[0] = 1'b0;
        chk("t5_tie_ch0_pkt", 32'(out_pkt), 32'h000F00);
        tick();
        chk("t5_tie_ch1", 32'(in_ready), 32'd2);
        tick(); in_valid = '0;
        chk("t5_tie_ch1_pkt", 32'(out_pkt), 32'h000F01);
        tick();

        // 4: step=1, seg_last=1325; ts=1575 -> RUN 14, held spike stale at 5000
        out_ready = 1'b0; time_us = 32'd5000;
        set_ch(0, 1'b1, 32'd1575, 24'h000111);
        tick(); in_valid = '0;
        chk("t4_run14", 32'(out_pkt), 32'h20000E);
        out_ready = 1'b1;
        tick();
        chk("t4_idle_valid", 32'(out_valid), 32'd0);
        tick();
        chk("t4_held_drop", 32'(drop_cnt), 32'd1);
        chk("t4_held_drop_nopkt", 32'(out_valid), 32'd0);
        set_ch(0, 1'b1, 32'd4700, 24'h000470); settle();
        chk("t4_stale_pop", 32'(in_ready), 32'd1);
        tick();
        chk("t4_drop2", 32'(drop_cnt), 32'd2);
        chk("t4_drop_nopkt", 32'(out_valid), 32'd0);
        repeat (65540) @(posedge clk);
        #1;
        chk("t4_drop_sat", 32'(drop_cnt), 32'h0000FFFF);
        set_ch(0, 1'b1, 32'd4800, 24'h000480); settle();
        chk("t4_fresh_pop", 32'(in_ready), 32'd1);
        tick(); in_valid = '0;
        chk("t4_fresh_start", 32'(out_pkt), 32'h400000);
        chk("t4_sat_hold", 32'(drop_cnt), 32'h0000FFFF);
        tick();
        chk("t4_fresh_spike", 32'(out_pkt), 32'h000480);
        tick();

        // 6: reset, wrap of seg_last, reset mid-RUN
        rst_n = 1'b0; settle();
        chk("t6_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        time_us = 32'hFFFFFFF8;
        tick();
        rst_n = 1'b1;
        tick();
        set_ch(0, 1'b1, 32'hFFFFFFF0, 24'h000777); settle();
        chk("t6_wrap_pop", 32'(in_ready), 32'd1);
        tick(); in_valid = '0;
        chk("t6_wrap_start", 32'(out_pkt), 32'h400000);
        tick();
        chk("t6_wrap_spike", 32'(out_pkt), 32'h000777);
        tick();
        out_ready = 1'b0;
        set_ch(0, 1'b1, 32'h00000005, 24'h000888);
        tick(); in_valid = '0;
        chk("t6_wrap_run1", 32'(out_pkt), 32'h200001);
        tick();
        chk("t6_run_hold", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0; settle();
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_pkt", 32'(out_pkt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
